// File: rtl/is_stage_pkg.sv
// is_stage_pkg: shared types and constants for the issue stage.
//   - OP_* : RISC-V major opcodes as inst[6:2]
//   - FU_* : functional-unit select codes (index into fu_ready)
//   - uop_t: the micro-op field bundle carried from dispatch to issue
//   - uses_rs1 / uses_rs2 / writes_rd: operand-use decode from the opcode
package is_stage_pkg;

   localparam int unsigned TAG_W = 7;

   localparam logic [4:0] OP_LOAD   = 5'h00;
   localparam logic [4:0] OP_FLOAD  = 5'h01;
   localparam logic [4:0] OP_I_TYPE = 5'h04;
   localparam logic [4:0] OP_AUIPC  = 5'h05;
   localparam logic [4:0] OP_S_TYPE = 5'h08;
   localparam logic [4:0] OP_FSTORE = 5'h09;
   localparam logic [4:0] OP_R_TYPE = 5'h0C;
   localparam logic [4:0] OP_LUI    = 5'h0D;
   localparam logic [4:0] OP_F_TYPE = 5'h14;
   localparam logic [4:0] OP_B_TYPE = 5'h18;
   localparam logic [4:0] OP_JALR   = 5'h19;
   localparam logic [4:0] OP_JAL    = 5'h1B;

   localparam logic [2:0] FU_ALU    = 3'd0;
   localparam logic [2:0] FU_MUL    = 3'd1;
   localparam logic [2:0] FU_DIV    = 3'd2;
   localparam logic [2:0] FU_BRANCH = 3'd3;
   localparam logic [2:0] FU_FPU    = 3'd4;
   localparam logic [2:0] FU_FDIV   = 3'd5;
   localparam logic [2:0] FU_LOAD   = 3'd6;
   localparam logic [2:0] FU_STORE  = 3'd7;

   typedef struct packed {
      logic [31:0]      pc;
      logic [31:0]      inst;
      logic [31:0]      imm;
      logic [4:0]       op;
      logic [2:0]       f3;
      logic [6:0]       f7;
      logic [TAG_W-1:0] P_rs1;
      logic [TAG_W-1:0] P_rs2;
      logic [TAG_W-1:0] P_rd;
      logic [2:0]       fu_sel;
      logic [2:0]       rob_idx;
      logic [1:0]       LQ_tail;
      logic [1:0]       SQ_tail;
      logic             jump;
   } uop_t;

   function automatic logic uses_rs1(input logic [4:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [4:0] op);
      return (op == OP_R_TYPE) || (op == OP_B_TYPE) || (op == OP_S_TYPE) ||
             (op == OP_FSTORE) || (op == OP_F_TYPE);
   endfunction

   function automatic logic writes_rd(input logic [4:0] op, input logic [TAG_W-1:0] p_rd);
      return !(op == OP_S_TYPE || op == OP_FSTORE || op == OP_B_TYPE) && (p_rd != '0);
   endfunction

endpackage

// File: rtl/is_busy_table.sv
// is_busy_table: physical-register busy vector with per-lane readiness lookup.
//   clk, rst          : clock, synchronous active-high reset (all bits clear)
//   i_set_en/_tag     : mark a tag busy (new producer enqueued); tag 0 ignored
//   i_clr_en/_tag     : writeback clear; also bypassed into the read ports
//   i_flush_mask      : bulk clear of flushed producers
//   i_rd1_tag/_rd2_tag: one rs1 and one rs2 read port, each NLANE lanes wide
//   o_rd1_rdy/_rd2_rdy: tag is ready (tag 0, not busy, or being written back now)
module is_busy_table
   import is_stage_pkg::*;
#(
   parameter int unsigned PREG  = 128,
   parameter int unsigned NLANE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_set_en,
   input  logic [TAG_W-1:0] i_set_tag,
   input  logic             i_clr_en,
   input  logic [TAG_W-1:0] i_clr_tag,
   input  logic [PREG-1:0]  i_flush_mask,
   input  logic [TAG_W-1:0] i_rd1_tag [NLANE],
   input  logic [TAG_W-1:0] i_rd2_tag [NLANE],
   output logic             o_rd1_rdy [NLANE],
   output logic             o_rd2_rdy [NLANE]
);

   logic [PREG-1:0] r_busy;
   logic [PREG-1:0] w_busy_d;

   // Clears first, then set, so a same-cycle set/clear of one tag leaves it busy.
   always_comb begin
      w_busy_d = r_busy & ~i_flush_mask;
      if (i_clr_en) w_busy_d[i_clr_tag] = 1'b0;
      if (i_set_en && (i_set_tag != '0)) w_busy_d[i_set_tag] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_busy <= '0;
      else     r_busy <= w_busy_d;
   end

   always_comb begin
      for (int i = 0; i < int'(NLANE); i++) begin
         o_rd1_rdy[i] = (i_rd1_tag[i] == '0) || !r_busy[i_rd1_tag[i]] ||
                        (i_clr_en && (i_clr_tag == i_rd1_tag[i]));
         o_rd2_rdy[i] = (i_rd2_tag[i] == '0) || !r_busy[i_rd2_tag[i]] ||
                        (i_clr_en && (i_clr_tag == i_rd2_tag[i]));
      end
   end

endmodule

// File: rtl/is_stage.sv
// is_stage: age-ordered collapsing issue queue between dispatch and register read.
//   clk, rst           : clock, synchronous active-high reset
//   in_*               : decoded/renamed uop from dispatch, qualified by in_valid
//   IS_ready           : queue has a free slot (registered count only)
//   fu_ready[8]        : per-FU accept, indexed by fu_sel, sampled at select
//   wb_valid, wb_P_rd  : writeback broadcast, clears busy and wakes consumers
//   mispredict         : flush all queued uops (highest priority)
//   stall              : freeze enqueue and issue; wakeups still apply
//   iss_valid, iss_*   : registered issued uop (fields hold when not issuing)
module is_stage
   import is_stage_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PREG  = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_op,
   input  logic [2:0]  in_f3,
   input  logic [6:0]  in_f7,
   input  logic [6:0]  in_P_rs1,
   input  logic [6:0]  in_P_rs2,
   input  logic [6:0]  in_P_rd,
   input  logic [2:0]  in_fu_sel,
   input  logic [2:0]  in_rob_idx,
   input  logic [1:0]  in_LQ_tail,
   input  logic [1:0]  in_SQ_tail,
   input  logic        in_jump,
   output logic        IS_ready,
   input  logic [7:0]  fu_ready,
   input  logic        wb_valid,
   input  logic [6:0]  wb_P_rd,
   input  logic        mispredict,
   input  logic        stall,
   output logic        iss_valid,
   output logic [31:0] iss_pc,
   output logic [31:0] iss_inst,
   output logic [31:0] iss_imm,
   output logic [4:0]  iss_op,
   output logic [2:0]  iss_f3,
   output logic [6:0]  iss_f7,
   output logic [6:0]  iss_P_rs1,
   output logic [6:0]  iss_P_rs2,
   output logic [6:0]  iss_P_rd,
   output logic [2:0]  iss_fu_sel,
   output logic [2:0]  iss_rob_idx,
   output logic [1:0]  iss_LQ_tail,
   output logic [1:0]  iss_SQ_tail,
   output logic        iss_jump
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   uop_t             r_q [DEPTH];
   logic [CNT_W-1:0] r_count;
   uop_t             r_iss;
   logic             r_iss_valid;

   uop_t             w_in;
   uop_t             w_q_d [DEPTH];
   logic [CNT_W-1:0] w_cnt_base;
   logic [CNT_W-1:0] w_count_d;
   logic [IDX_W-1:0] w_sel_idx;
   logic             w_sel_any;
   logic             w_issue;
   logic             w_enq;
   logic [PREG-1:0]  w_flush_mask;
   logic [TAG_W-1:0] w_rd1_tag [DEPTH];
   logic [TAG_W-1:0] w_rd2_tag [DEPTH];
   logic             w_rd1_rdy [DEPTH];
   logic             w_rd2_rdy [DEPTH];
   logic [DEPTH-1:0] w_cand;

   always_comb begin
      w_in.pc      = in_pc;
      w_in.inst    = in_inst;
      w_in.imm     = in_imm;
      w_in.op      = in_op;
      w_in.f3      = in_f3;
      w_in.f7      = in_f7;
      w_in.P_rs1   = in_P_rs1;
      w_in.P_rs2   = in_P_rs2;
      w_in.P_rd    = in_P_rd;
      w_in.fu_sel  = in_fu_sel;
      w_in.rob_idx = in_rob_idx;
      w_in.LQ_tail = in_LQ_tail;
      w_in.SQ_tail = in_SQ_tail;
      w_in.jump    = in_jump;
   end

   assign IS_ready = (r_count < CNT_W'(DEPTH));
   assign w_enq    = in_valid && IS_ready && !stall && !mispredict;

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_rd1_tag[i] = r_q[i].P_rs1;
         w_rd2_tag[i] = r_q[i].P_rs2;
      end
   end

   is_busy_table #(
      .PREG  (PREG),
      .NLANE (DEPTH)
   ) u_busy (
      .clk          (clk),
      .rst          (rst),
      .i_set_en     (w_enq && writes_rd(in_op, in_P_rd)),
      .i_set_tag    (in_P_rd),
      .i_clr_en     (wb_valid),
      .i_clr_tag    (wb_P_rd),
      .i_flush_mask (w_flush_mask),
      .i_rd1_tag    (w_rd1_tag),
      .i_rd2_tag    (w_rd2_tag),
      .o_rd1_rdy    (w_rd1_rdy),
      .o_rd2_rdy    (w_rd2_rdy)
   );

   // Oldest-first select: scan from the top down so the lowest index wins.
   always_comb begin
      w_sel_idx = '0;
      w_sel_any = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_cand[i] = (CNT_W'(i) < r_count) &&
                     (!uses_rs1(r_q[i].op) || w_rd1_rdy[i]) &&
                     (!uses_rs2(r_q[i].op) || w_rd2_rdy[i]) &&
                     fu_ready[r_q[i].fu_sel];
      end
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            w_sel_idx = IDX_W'(i);
            w_sel_any = 1'b1;
         end
      end
   end

   assign w_issue = w_sel_any && !stall && !mispredict;

   // Collapse above the issued slot, then append behind the surviving entries.
   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) w_q_d[i] = r_q[i];
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         if (w_issue && (IDX_W'(i) >= w_sel_idx)) w_q_d[i] = r_q[i + 1];
      end
      w_cnt_base = r_count - CNT_W'(w_issue);
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (w_enq && (CNT_W'(i) == w_cnt_base)) w_q_d[i] = w_in;
      end
      w_count_d = mispredict ? '0 : (w_cnt_base + CNT_W'(w_enq));
   end

   // Flushed producers will never write back, so release their destination tags.
   always_comb begin
      w_flush_mask = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (mispredict && (CNT_W'(i) < r_count) && writes_rd(r_q[i].op, r_q[i].P_rd)) begin
            w_flush_mask[r_q[i].P_rd] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= '0;
         r_count     <= '0;
         r_iss       <= '0;
         r_iss_valid <= 1'b0;
      end else begin
         for (int i = 0; i < int'(DEPTH); i++) r_q[i] <= w_q_d[i];
         r_count     <= w_count_d;
         r_iss_valid <= w_issue;
         if (w_issue) r_iss <= r_q[w_sel_idx];
      end
   end

   assign iss_valid   = r_iss_valid;
   assign iss_pc      = r_iss.pc;
   assign iss_inst    = r_iss.inst;
   assign iss_imm     = r_iss.imm;
   assign iss_op      = r_iss.op;
   assign iss_f3      = r_iss.f3;
   assign iss_f7      = r_iss.f7;
   assign iss_P_rs1   = r_iss.P_rs1;
   assign iss_P_rs2   = r_iss.P_rs2;
   assign iss_P_rd    = r_iss.P_rd;
   assign iss_fu_sel  = r_iss.fu_sel;
   assign iss_rob_idx = r_iss.rob_idx;
   assign iss_LQ_tail = r_iss.LQ_tail;
   assign iss_SQ_tail = r_iss.SQ_tail;
   assign iss_jump    = r_iss.jump;

endmodule
